// File: rtl/riscie_pkg.sv
// Shared constants for the execute stage: datapath width, func3/func7 decodes
// and the state encoding of the iterative multiply/divide unit.
package riscie_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;
  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, with sign fix-up applied in the DONE state.
module muldiv_iter
  import riscie_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, den_q, den_d, araw_q, araw_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, negr_q, negr_d, dz_q, dz_d;

  logic            a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] amag, bmag;
  logic [XLEN:0]   shifted, sum;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s;

  always_comb begin
    a_signed = op_i inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = op_i inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    sa       = a_signed & a_i[XLEN-1];
    sb       = b_signed & b_i[XLEN-1];
    amag     = sa ? -a_i : a_i;
    bmag     = sb ? -b_i : b_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    den_d   = den_q;
    araw_d  = araw_q;
    op_d    = op_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    shifted = {hi_q, lo_q[XLEN-1]};
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
    unique case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(XLEN - 1);
          hi_d    = '0;
          lo_d    = amag;
          den_d   = bmag;
          araw_d  = a_i;
          op_d    = op_i;
          neg_d   = sa ^ sb;
          negr_d  = sa;
          dz_d    = (b_i == '0);
        end
      end
      MD_BUSY: begin
        // hi holds the partial remainder (divide) or the running upper product (multiply);
        // a remainder never exceeds the divisor, so XLEN bits suffice in both branches.
        if (op_q[2]) begin
          if (shifted >= {1'b0, den_q}) begin
            hi_d = XLEN'(shifted - {1'b0, den_q});
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = shifted[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = sum[XLEN:1];
          lo_d = {sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) state_d = MD_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      den_q   <= '0;
      araw_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      den_q   <= den_d;
      araw_q  <= araw_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_q : lo_q;
    rem_s  = negr_q ? -hi_q : hi_q;
    unique case (op_q)
      F3_MUL:                        result_o = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result_o = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               result_o = dz_q ? '1 : quo_s;
      default:                       result_o = dz_q ? araw_q : rem_s;
    endcase
  end

  assign busy_o = (state_q == MD_BUSY);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/stage3.sv
// Execute stage: RV32I ALU, iterative RV32M unit, upstream stall and the
// EX/MEM pipeline registers.
module stage3
  import riscie_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        idexValid,
  input  logic [31:0] idexPc,
  input  logic [31:0] idexData1,
  input  logic [31:0] idexData2,
  input  logic [4:0]  idexRd,
  input  logic [6:0]  idexFunc7,
  input  logic [2:0]  idexFunc3,
  input  logic [63:0] idexExpandInst,
  input  logic        idexUseImm,
  input  logic        idexRegWrite,
  output logic        stall,
  output logic        exmemValid,
  output logic [31:0] exmemPc,
  output logic [31:0] exmemAluResult,
  output logic [31:0] exmemData2,
  output logic [4:0]  exmemRd,
  output logic        exmemRegWrite
);

  logic [XLEN-1:0] opb, alu_res, md_res;
  logic [4:0]      shamt;
  logic            mop, md_busy, md_done;
  logic            unused_imm_hi;

  logic            valid_q, regwr_q;
  logic [31:0]     pc_q, res_q, data2_q;
  logic [4:0]      rd_q;

  assign unused_imm_hi = ^idexExpandInst[63:32];

  assign opb   = idexUseImm ? idexExpandInst[31:0] : idexData2;
  assign shamt = opb[4:0];
  assign mop   = idexValid && !idexUseImm && (idexFunc7 == FUNC7_MULDIV);

  always_comb begin
    alu_res = '0;
    unique case (idexFunc3)
      F3_ADD:  alu_res = (!idexUseImm && idexFunc7 == FUNC7_ALT) ? idexData1 - opb
                                                                  : idexData1 + opb;
      F3_SLL:  alu_res = idexData1 << shamt;
      F3_SLT:  alu_res[0] = $signed(idexData1) < $signed(opb);
      F3_SLTU: alu_res[0] = idexData1 < opb;
      F3_XOR:  alu_res = idexData1 ^ opb;
      F3_SR:   alu_res = idexFunc7[5] ? XLEN'($signed(idexData1) >>> shamt)
                                      : idexData1 >> shamt;
      F3_OR:   alu_res = idexData1 | opb;
      default: alu_res = idexData1 & opb;
    endcase
  end

  muldiv_iter u_muldiv (
    .clk_i    (clk),
    .rst_i    (reset),
    .start_i  (mop),
    .op_i     (idexFunc3),
    .a_i      (idexData1),
    .b_i      (idexData2),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // The DONE cycle releases the stall while the M-op is still held in ID/EX.
  assign stall = !reset && (md_busy || (mop && !md_done));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      pc_q    <= '0;
      res_q   <= '0;
      data2_q <= '0;
      rd_q    <= '0;
    end else if (stall) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
    end else begin
      valid_q <= idexValid;
      regwr_q <= idexValid && idexRegWrite;
      pc_q    <= idexPc;
      res_q   <= mop ? md_res : alu_res;
      data2_q <= idexData2;
      rd_q    <= idexRd;
    end
  end

  assign exmemValid     = valid_q;
  assign exmemRegWrite  = regwr_q;
  assign exmemPc        = pc_q;
  assign exmemAluResult = res_q;
  assign exmemData2     = data2_q;
  assign exmemRd        = rd_q;

endmodule

// File: tb/tb_stage3.sv
// Directed bench for stage3: table of single-cycle ALU vectors, then M-op,
// reset-abort and back-to-back sequences with hand-computed results.
module tb_stage3;
  import riscie_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        idexValid, idexUseImm, idexRegWrite;
  logic [31:0] idexPc, idexData1, idexData2;
  logic [4:0]  idexRd;
  logic [6:0]  idexFunc7;
  logic [2:0]  idexFunc3;
  logic [63:0] idexExpandInst;
  logic        stall, exmemValid, exmemRegWrite;
  logic [31:0] exmemPc, exmemAluResult, exmemData2;
  logic [4:0]  exmemRd;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    string       name;
    logic        use_imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[14];

  stage3 dut (
    .clk            (clk),
    .reset          (reset),
    .idexValid      (idexValid),
    .idexPc         (idexPc),
    .idexData1      (idexData1),
    .idexData2      (idexData2),
    .idexRd         (idexRd),
    .idexFunc7      (idexFunc7),
    .idexFunc3      (idexFunc3),
    .idexExpandInst (idexExpandInst),
    .idexUseImm     (idexUseImm),
    .idexRegWrite   (idexRegWrite),
    .stall          (stall),
    .exmemValid     (exmemValid),
    .exmemPc        (exmemPc),
    .exmemAluResult (exmemAluResult),
    .exmemData2     (exmemData2),
    .exmemRd        (exmemRd),
    .exmemRegWrite  (exmemRegWrite)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic alu_vec_t mk(string n, logic ui, logic [2:0] f3, logic [6:0] f7,
                                  logic [31:0] d1, logic [31:0] d2, logic [31:0] imm,
                                  logic rw, logic [31:0] exp);
    alu_vec_t v;
    v.name = n; v.use_imm = ui; v.f3 = f3; v.f7 = f7;
    v.d1 = d1; v.d2 = d2; v.imm = imm; v.rw = rw; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ui, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic rw, input logic [31:0] pc, input logic [4:0] rd);
    idexValid      = v;
    idexUseImm     = ui;
    idexFunc3      = f3;
    idexFunc7      = f7;
    idexData1      = d1;
    idexData2      = d2;
    idexExpandInst = {{32{imm[31]}}, imm};
    idexRegWrite   = rw;
    idexPc         = pc;
    idexRd         = rd;
  endtask

  task automatic run_alu(input string name, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] exp);
    drive(1'b1, 1'b0, F3_ADD, 7'b0, d1, d2, 32'h0, 1'b1, 32'h2000, 5'd9);
    #1;
    check({name, "_stall"}, 32'(stall), 32'h0);
    @(posedge clk); #1;
    check({name, "_res"}, exmemAluResult, exp);
    check({name, "_valid"}, 32'(exmemValid), 32'h1);
  endtask

  // Drives an M-op and holds it while stall is high, as the upstream stages would.
  task automatic run_mop(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int unsigned cyc;
    logic bub_ok;
    drive(1'b1, 1'b0, f3, FUNC7_MULDIV, a, b, 32'h0, 1'b1, 32'h3000, 5'd7);
    #1;
    cyc = 0;
    bub_ok = 1'b1;
    while (stall && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
      if (exmemValid !== 1'b0 || exmemRegWrite !== 1'b0) bub_ok = 1'b0;
    end
    check({name, "_stallcycles"}, 32'(cyc), 32'd33);
    check({name, "_bubbles"}, 32'(bub_ok), 32'h1);
    @(posedge clk); #1;
    check({name, "_res"}, exmemAluResult, exp);
    check({name, "_valid"}, 32'({exmemValid, exmemRegWrite}), 32'h3);
  endtask

  initial begin
    logic bub_ok;
    vecs[0]  = mk("add",      0, F3_ADD,  7'h00,     32'd5,        32'd7,        32'h0,        1, 32'd12);
    vecs[1]  = mk("sub",      0, F3_ADD,  FUNC7_ALT, 32'd5,        32'd7,        32'h0,        1, 32'hFFFFFFFE);
    vecs[2]  = mk("addi_neg", 1, F3_ADD,  7'h7F,     32'd10,       32'h0,        32'hFFFFFFFC, 1, 32'd6);
    vecs[3]  = mk("sra",      0, F3_SR,   FUNC7_ALT, 32'h80000000, 32'd4,        32'h0,        1, 32'hF8000000);
    vecs[4]  = mk("srl",      0, F3_SR,   7'h00,     32'h80000000, 32'd4,        32'h0,        1, 32'h08000000);
    vecs[5]  = mk("sll_mask", 0, F3_SLL,  7'h00,     32'h1,        32'h3F,       32'h0,        1, 32'h80000000);
    vecs[6]  = mk("slt",      0, F3_SLT,  7'h00,     32'hFFFFFFFF, 32'd1,        32'h0,        1, 32'd1);
    vecs[7]  = mk("sltu",     0, F3_SLTU, 7'h00,     32'hFFFFFFFF, 32'd1,        32'h0,        1, 32'd0);
    vecs[8]  = mk("xor",      0, F3_XOR,  7'h00,     32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        1, 32'hFF00FF00);
    vecs[9]  = mk("or",       0, F3_OR,   7'h00,     32'hF0000000, 32'h0000000F, 32'h0,        1, 32'hF000000F);
    vecs[10] = mk("and",      0, F3_AND,  7'h00,     32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        1, 32'h0F000F00);
    vecs[11] = mk("addi_alt", 1, F3_ADD,  FUNC7_ALT, 32'd5,        32'd100,      32'd3,        1, 32'd8);
    vecs[12] = mk("add_wrap", 0, F3_ADD,  7'h00,     32'hFFFFFFFF, 32'd1,        32'h0,        0, 32'd0);
    vecs[13] = mk("slti",     1, F3_SLT,  7'h00,     32'hFFFFFFF0, 32'd0,        32'hFFFFFFF8, 1, 32'd1);

    reset = 1'b1;
    drive(1'b0, 1'b0, 3'b0, 7'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall",  32'(stall), 32'h0);
    check("rst_valid",  32'({exmemValid, exmemRegWrite}), 32'h0);
    check("rst_result", exmemAluResult, 32'h0);
    check("rst_fields", exmemPc | exmemData2 | 32'(exmemRd), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].use_imm, vecs[i].f3, vecs[i].f7, vecs[i].d1, vecs[i].d2,
            vecs[i].imm, vecs[i].rw, 32'h1000 + 32'(4 * i), 5'(i));
      #1;
      check({vecs[i].name, "_stall"}, 32'(stall), 32'h0);
      @(posedge clk); #1;
      check({vecs[i].name, "_res"}, exmemAluResult, vecs[i].exp);
      check({vecs[i].name, "_ctl"}, 32'({exmemValid, exmemRegWrite}), 32'({1'b1, vecs[i].rw}));
      check({vecs[i].name, "_fwd"}, {exmemPc[26:0], exmemRd}, {27'(32'h1000 + 32'(4 * i)), 5'(i)});
      check({vecs[i].name, "_data2"}, exmemData2, vecs[i].d2);
    end

    run_mop("mul",      F3_MUL,    32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6);
    run_mop("mulh",     F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
    run_mop("mulhu",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_mop("mulhsu",   F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_mop("div_z",    F3_DIV,    32'd7,        32'd0,        32'hFFFFFFFF);
    run_mop("rem_z",    F3_REM,    32'd7,        32'd0,        32'd7);
    run_mop("div_ovf",  F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_mop("rem_ovf",  F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0);
    run_mop("divu",     F3_DIVU,   32'd100,      32'd7,        32'd14);
    run_mop("remu",     F3_REMU,   32'd100,      32'd7,        32'd2);
    run_mop("div_neg",  F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_mop("rem_neg",  F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_mop("divu_z",   F3_DIVU,   32'h80000005, 32'd0,        32'hFFFFFFFF);
    run_mop("remu_z",   F3_REMU,   32'h80000005, 32'd0,        32'h80000005);

    // Reset ten cycles into a DIV; upstream flushes ID/EX along with it.
    drive(1'b1, 1'b0, F3_DIV, FUNC7_MULDIV, 32'd1000, 32'd3, 32'h0, 1'b1, 32'h4000, 5'd3);
    repeat (10) @(posedge clk);
    #1;
    check("midop_stall_before", 32'(stall), 32'h1);
    reset = 1'b1;
    idexValid = 1'b0;
    @(posedge clk); #1;
    check("midop_stall_after", 32'(stall), 32'h0);
    check("midop_valid_after", 32'({exmemValid, exmemRegWrite}), 32'h0);
    reset = 1'b0;
    bub_ok = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (exmemValid !== 1'b0 || stall !== 1'b0) bub_ok = 1'b0;
    end
    check("midop_no_result", 32'(bub_ok), 32'h1);
    run_alu("post_reset_add", 32'd5, 32'd7, 32'd12);

    // Back-to-back: MUL, then ADD on the very next edge, then a bubble.
    run_mop("b2b_mul", F3_MUL, 32'd1234, 32'd1000, 32'd1234000);
    run_alu("b2b_add", 32'd40, 32'd2, 32'd42);
    drive(1'b0, 1'b0, F3_ADD, 7'b0, 32'd1, 32'd1, 32'h0, 1'b1, 32'h5000, 5'd4);
    #1;
    check("bubble_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("bubble_valid", 32'(exmemValid), 32'h0);
    check("bubble_regwrite", 32'(exmemRegWrite), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
